// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundles the pipeline-control request inputs and the
// stall/flush/redirect/counter outputs of pipe_ctrl. The pipeline side uses
// the master modport; pipe_ctrl uses the slave modport.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [7:0]  mem_exp_no;
  logic [31:0] mem_exp_retpc;
  logic [31:0] idt_base;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [7:0]  exc_no;
  logic [31:0] exc_retpc;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  dbg_state;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, mem_exp_no, mem_exp_retpc,
           idt_base, cnt_clr,
    input  stall, flush, new_pc, exc_no, exc_retpc, stall_cnt, flush_cnt,
           dbg_state
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, mem_exp_no, mem_exp_retpc,
           idt_base, cnt_clr,
    output stall, flush, new_pc, exc_no, exc_retpc, stall_cnt, flush_cnt,
           dbg_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the six-stage pipeline (PC IF ID EX MEM WB).
// Merges stage stall requests into a stall vector, turns MEM-stage exceptions
// into a one-cycle registered flush with a redirect PC, and keeps saturating
// stall/flush performance counters.
// Optional watchdog for endless stalls: define PIPE_CTRL_WDT_EN.
//
// Exception handshake: mem_exp_no != 8'hFF is the valid; the unit is ready
// only in IDLE. An offer made while not ready (FLUSH/RECOVER) is dropped,
// never held, because it belongs to the wrong path being flushed.
module pipe_ctrl #(
  parameter int unsigned WDT_LIMIT  = 255,
  parameter logic [7:0]  WDT_EXP_NO = 8'h1F
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_RECOVER = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  req_vec;
  logic [5:0]  stall;
  logic        exc_valid;
  logic        wdt_fire;
  logic        take_exc;
  logic [7:0]  sel_no;
  logic [31:0] sel_retpc;
  logic [7:0]  exc_no_q, exc_no_d;
  logic [31:0] exc_retpc_q, exc_retpc_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Merge stall requests: the deepest requesting stage holds itself and all upstream stages.
  always_comb begin
    req_vec = 6'b000000;
    if (bus.stallreq_mem)     req_vec = 6'b011111;
    else if (bus.stallreq_ex) req_vec = 6'b001111;
    else if (bus.stallreq_id) req_vec = 6'b000111;
  end

  assign stall     = (state_q == ST_IDLE) ? req_vec : 6'b000000;
  assign exc_valid = (bus.mem_exp_no != 8'hFF);

`ifdef PIPE_CTRL_WDT_EN
  logic [31:0] wdt_q, wdt_d;

  assign wdt_fire = (stall != 6'b000000) && (wdt_q == WDT_LIMIT - 32'd1);

  // Count consecutive stalled IDLE cycles; any unstalled cycle or a taken exception restarts it.
  always_comb begin
    wdt_d = 32'd0;
    if ((stall != 6'b000000) && !take_exc) wdt_d = wdt_q + 32'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdt_q <= 32'd0;
    else      wdt_q <= wdt_d;
  end
`else
  logic unused_wdt_limit;
  assign unused_wdt_limit = ^WDT_LIMIT;
  assign wdt_fire         = 1'b0;
`endif

  // Next state and exception selection; a real exception beats the watchdog.
  always_comb begin
    state_d   = state_q;
    take_exc  = 1'b0;
    sel_no    = bus.mem_exp_no;
    sel_retpc = bus.mem_exp_retpc;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          take_exc = 1'b1;
        end else if (wdt_fire) begin
          take_exc  = 1'b1;
          sel_no    = WDT_EXP_NO;
          sel_retpc = exc_retpc_q;
        end
        if (take_exc) state_d = ST_FLUSH;
      end
      ST_FLUSH:   state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Redirect registers and saturating counters; clear beats increment.
  always_comb begin
    exc_no_d    = exc_no_q;
    exc_retpc_d = exc_retpc_q;
    new_pc_d    = new_pc_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (take_exc) begin
      exc_no_d    = sel_no;
      exc_retpc_d = sel_retpc;
      new_pc_d    = bus.idt_base + {21'd0, sel_no, 3'b000};
    end
    if (bus.cnt_clr) begin
      stall_cnt_d = 32'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if ((stall != 6'b000000) && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (take_exc && (flush_cnt_q != 16'hFFFF))                  flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // State, redirect and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      exc_no_q    <= 8'hFF;
      exc_retpc_q <= 32'd0;
      new_pc_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      exc_no_q    <= exc_no_d;
      exc_retpc_q <= exc_retpc_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = (state_q == ST_FLUSH);
  assign bus.new_pc    = new_pc_q;
  assign bus.exc_no    = exc_no_q;
  assign bus.exc_retpc = exc_retpc_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios with constant expectations plus a
// randomized run checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
  localparam int unsigned WDT_LIM = 4;
  localparam logic [7:0]  WDT_NO  = 8'h1F;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.WDT_LIMIT(WDT_LIM), .WDT_EXP_NO(WDT_NO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // m_blocked: cycles the unit still ignores inputs after accepting an
  // exception (2 = flush cycle, 1 = recover cycle, 0 = accepting).
  int          m_blocked;
  int          m_wdt;
  logic [31:0] m_stall_cnt;
  logic [15:0] m_flush_cnt;
  logic [31:0] m_new_pc;
  logic [31:0] m_retpc;
  logic [7:0]  m_exc_no;
  logic [39:0] exp_q[$];

  task automatic model_reset();
    m_blocked   = 0;
    m_wdt       = 0;
    m_stall_cnt = 32'd0;
    m_flush_cnt = 16'd0;
    m_new_pc    = 32'd0;
    m_retpc     = 32'd0;
    m_exc_no    = 8'hFF;
    exp_q.delete();
  endtask

  // Number of held stages = index of the deepest requesting stage + 1.
  function automatic logic [5:0] model_stall();
    int held;
    held = 0;
    if (m_blocked == 0) begin
      if (bus.stallreq_mem)     held = 5;
      else if (bus.stallreq_ex) held = 4;
      else if (bus.stallreq_id) held = 3;
    end
    return 6'((1 << held) - 1);
  endfunction

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    logic [5:0]  s;
    logic [7:0]  eno;
    logic [31:0] erp;
    bit          acc;
    s   = model_stall();
    eno = bus.mem_exp_no;
    erp = bus.mem_exp_retpc;
    acc = 1'b0;
`ifdef PIPE_CTRL_WDT_EN
    if ((s != 6'd0) && (eno == 8'hFF) && (m_wdt + 1 == int'(WDT_LIM))) begin
      eno = WDT_NO;
      erp = m_retpc;
    end
`endif
    if (m_blocked > 0) begin
      m_blocked--;
    end else if (eno != 8'hFF) begin
      acc       = 1'b1;
      m_blocked = 2;
      m_exc_no  = eno;
      m_retpc   = erp;
      m_new_pc  = bus.idt_base + 32'(eno) * 32'd8;
      exp_q.push_back({eno, m_new_pc});
    end
    m_wdt = ((s != 6'd0) && !acc) ? m_wdt + 1 : 0;
    if (bus.cnt_clr) begin
      m_stall_cnt = 32'd0;
      m_flush_cnt = 16'd0;
    end else begin
      if ((s != 6'd0) && (m_stall_cnt != 32'hFFFF_FFFF)) m_stall_cnt++;
      if (acc && (m_flush_cnt != 16'hFFFF))              m_flush_cnt++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.stallreq_id   = 1'b0;
    bus.stallreq_ex   = 1'b0;
    bus.stallreq_mem  = 1'b0;
    bus.mem_exp_no    = 8'hFF;
    bus.mem_exp_retpc = 32'd0;
    bus.cnt_clr       = 1'b0;
  endtask

  // One cycle: account the edge just passed in the model, apply new inputs,
  // then settle so the caller can sample mid-cycle.
  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [7:0] eno, input logic [31:0] rpc, input logic clr);
    @(negedge clk);
    model_edge();
    bus.stallreq_id   = id;
    bus.stallreq_ex   = ex;
    bus.stallreq_mem  = mem;
    bus.mem_exp_no    = eno;
    bus.mem_exp_retpc = rpc;
    bus.cnt_clr       = clr;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    bus.idt_base = 32'h0000_1000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.idt_base = 32'h0000_1000;
    @(negedge clk);
    #1;
    n_vec++; if (bus.stall !== 6'd0) begin n_err++; $display("FAIL reset_stall: got %b want %b", bus.stall, 6'd0); end
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    n_vec++; if (bus.new_pc !== 32'd0) begin n_err++; $display("FAIL reset_new_pc: got %h want 0", bus.new_pc); end
    n_vec++; if (bus.exc_retpc !== 32'd0) begin n_err++; $display("FAIL reset_retpc: got %h want 0", bus.exc_retpc); end
    n_vec++; if (bus.exc_no !== 8'hFF) begin n_err++; $display("FAIL reset_exc_no: got %h want ff", bus.exc_no); end
    n_vec++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); end
    n_vec++; if (bus.flush_cnt !== 16'd0) begin n_err++; $display("FAIL reset_flush_cnt: got %0d want 0", bus.flush_cnt); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stall_priority();
    apply_reset();
    drive(1, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall !== 6'b000111) begin n_err++; $display("FAIL prio_id: got %b want 000111", bus.stall); end
    drive(1, 1, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall !== 6'b001111) begin n_err++; $display("FAIL prio_ex: got %b want 001111", bus.stall); end
    drive(1, 1, 1, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall !== 6'b011111) begin n_err++; $display("FAIL prio_mem: got %b want 011111", bus.stall); end
    drive(0, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall !== 6'd0) begin n_err++; $display("FAIL prio_none: got %b want 000000", bus.stall); end
    n_vec++; if (bus.stall_cnt !== 32'd3) begin n_err++; $display("FAIL prio_stall_cnt: got %0d want 3", bus.stall_cnt); end
  endtask

  task automatic test_exception();
    apply_reset();
    drive(0, 0, 0, 8'h0E, 32'h0040_0024, 0);
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL exc_n_flush: got %b want 0", bus.flush); end
    drive(0, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL exc_n1_flush: got %b want 1", bus.flush); end
    n_vec++; if (bus.new_pc !== 32'h0000_1070) begin n_err++; $display("FAIL exc_new_pc: got %h want 00001070", bus.new_pc); end
    n_vec++; if (bus.exc_no !== 8'h0E) begin n_err++; $display("FAIL exc_no: got %h want 0e", bus.exc_no); end
    n_vec++; if (bus.exc_retpc !== 32'h0040_0024) begin n_err++; $display("FAIL exc_retpc: got %h want 00400024", bus.exc_retpc); end
    n_vec++; if (bus.flush_cnt !== 16'd1) begin n_err++; $display("FAIL exc_flush_cnt: got %0d want 1", bus.flush_cnt); end
    drive(0, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL exc_n2_flush: got %b want 0", bus.flush); end
    n_vec++; if (bus.new_pc !== 32'h0000_1070) begin n_err++; $display("FAIL exc_hold_pc: got %h want 00001070", bus.new_pc); end
  endtask

  task automatic test_stall_with_exc();
    apply_reset();
    drive(0, 0, 1, 8'h05, 32'h0000_0100, 0);
    n_vec++; if (bus.stall !== 6'b011111) begin n_err++; $display("FAIL swe_n_stall: got %b want 011111", bus.stall); end
    drive(0, 0, 1, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall !== 6'd0) begin n_err++; $display("FAIL swe_n1_stall: got %b want 000000", bus.stall); end
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL swe_n1_flush: got %b want 1", bus.flush); end
    drive(0, 0, 1, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall !== 6'd0) begin n_err++; $display("FAIL swe_n2_stall: got %b want 000000", bus.stall); end
    drive(0, 0, 1, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall !== 6'b011111) begin n_err++; $display("FAIL swe_n3_stall: got %b want 011111", bus.stall); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive(0, 0, 0, 8'h10, 32'h0000_0010, 0);
    drive(0, 0, 0, 8'h11, 32'h0000_0011, 0);
    n_vec++; if (bus.flush !== 1'b1 || bus.exc_no !== 8'h10) begin n_err++; $display("FAIL b2b_first: got flush=%b no=%h want flush=1 no=10", bus.flush, bus.exc_no); end
    drive(0, 0, 0, 8'h12, 32'h0000_0012, 0);
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL b2b_n2_flush: got %b want 0", bus.flush); end
    drive(0, 0, 0, 8'h13, 32'h0000_0013, 0);
    n_vec++; if (bus.flush !== 1'b0 || bus.flush_cnt !== 16'd1 || bus.exc_no !== 8'h10) begin n_err++; $display("FAIL b2b_ignored: got flush=%b cnt=%0d no=%h want flush=0 cnt=1 no=10", bus.flush, bus.flush_cnt, bus.exc_no); end
    drive(0, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.flush !== 1'b1 || bus.exc_no !== 8'h13) begin n_err++; $display("FAIL b2b_n3_taken: got flush=%b no=%h want flush=1 no=13", bus.flush, bus.exc_no); end
    n_vec++; if (bus.new_pc !== 32'h0000_1098 || bus.exc_retpc !== 32'h0000_0013) begin n_err++; $display("FAIL b2b_redirect: got pc=%h ret=%h want pc=00001098 ret=00000013", bus.new_pc, bus.exc_retpc); end
    n_vec++; if (bus.flush_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_flush_cnt: got %0d want 2", bus.flush_cnt); end
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(0, 0, 1, 8'hFF, 32'd0, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffffffff", bus.stall_cnt); end
    drive(0, 0, 1, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_no_wrap: got %h want ffffffff", bus.stall_cnt); end
    drive(0, 0, 1, 8'hFF, 32'd0, 1);
    drive(0, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 16'd0) begin n_err++; $display("FAIL sat_clear: got stall_cnt=%h flush_cnt=%h want 0 0", bus.stall_cnt, bus.flush_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    apply_reset();
    drive(0, 0, 0, 8'h22, 32'h0000_2222, 0);
    drive(0, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL rmf_pre: got %b want 1", bus.flush); end
    #1;
    rst = 1'b0;
    #1;
    n_vec++; if (bus.flush !== 1'b0 || bus.exc_no !== 8'hFF || bus.new_pc !== 32'd0) begin n_err++; $display("FAIL rmf_drop: got flush=%b no=%h pc=%h want 0 ff 0", bus.flush, bus.exc_no, bus.new_pc); end
  endtask

  task automatic test_watchdog();
    int flushes;
    apply_reset();
    flushes = 0;
`ifdef PIPE_CTRL_WDT_EN
    for (int i = 0; i < int'(WDT_LIM); i++) begin
      drive(0, 0, 1, 8'hFF, 32'd0, 0);
      if (bus.flush === 1'b1) flushes++;
    end
    n_vec++; if (flushes != 0) begin n_err++; $display("FAIL wdt_early: got %0d flushes want 0", flushes); end
    drive(0, 0, 1, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.flush !== 1'b1 || bus.exc_no !== WDT_NO) begin n_err++; $display("FAIL wdt_fire: got flush=%b no=%h want flush=1 no=1f", bus.flush, bus.exc_no); end
    n_vec++; if (bus.new_pc !== 32'h0000_10F8 || bus.exc_retpc !== 32'd0) begin n_err++; $display("FAIL wdt_redirect: got pc=%h ret=%h want pc=000010f8 ret=0", bus.new_pc, bus.exc_retpc); end
`else
    for (int i = 0; i < 1000; i++) begin
      drive(0, 0, 1, 8'hFF, 32'd0, 0);
      if (bus.flush === 1'b1) flushes++;
    end
    n_vec++; if (flushes != 0) begin n_err++; $display("FAIL nowdt_flush: got %0d flushes want 0", flushes); end
    n_vec++; if (bus.stall !== 6'b011111) begin n_err++; $display("FAIL nowdt_stall: got %b want 011111", bus.stall); end
    drive(0, 0, 0, 8'hFF, 32'd0, 0);
    n_vec++; if (bus.stall_cnt !== 32'd1000) begin n_err++; $display("FAIL nowdt_cnt: got %0d want 1000", bus.stall_cnt); end
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    logic [7:0]  eno;
    logic [39:0] got;
    logic [39:0] want;
    apply_reset();
    bus.idt_base = $urandom;
    for (int i = 0; i < 400; i++) begin
      eno = ($urandom_range(0, 99) < 15) ? 8'($urandom_range(0, 254)) : 8'hFF;
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
            eno, $urandom, $urandom_range(0, 99) < 3);
      n_vec++; if (bus.stall !== model_stall()) begin n_err++; $display("FAIL rnd_stall @%0d: got %b want %b", i, bus.stall, model_stall()); end
      n_vec++; if (bus.flush !== (m_blocked == 2)) begin n_err++; $display("FAIL rnd_flush @%0d: got %b want %b", i, bus.flush, (m_blocked == 2)); end
      n_vec++; if (bus.exc_no !== m_exc_no || bus.exc_retpc !== m_retpc || bus.new_pc !== m_new_pc) begin n_err++; $display("FAIL rnd_redirect @%0d: got %h/%h/%h want %h/%h/%h", i, bus.exc_no, bus.exc_retpc, bus.new_pc, m_exc_no, m_retpc, m_new_pc); end
      n_vec++; if (bus.stall_cnt !== m_stall_cnt || bus.flush_cnt !== m_flush_cnt) begin n_err++; $display("FAIL rnd_counters @%0d: got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, m_stall_cnt, m_flush_cnt); end
      if (bus.flush === 1'b1) begin
        got = {bus.exc_no, bus.new_pc};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 40'hFF_FFFF_FFFF;
        n_vec++; if (got !== want) begin n_err++; $display("FAIL rnd_scoreboard @%0d: got %h want %h", i, got, want); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_leftover: got %0d pending want 0", exp_q.size()); end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_inputs();
    bus.idt_base = 32'h0000_1000;
    model_reset();
    test_reset();
    test_stall_priority();
    test_exception();
    test_stall_with_exc();
    test_back_to_back();
    test_saturation();
    test_reset_mid_flush();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
